// File: rtl/axi_stream_extractor_pkg.sv
// Shared constants for the multi-channel stream extractor.
// Holds the full-FIFO policy codes and the drop-counter helper.
package axi_stream_extractor_pkg;

    localparam int MODE_BACKPRESSURE = 0;
    localparam int MODE_DROP         = 1;
    localparam int DROP_CNT_WIDTH    = 16;

    function automatic logic [DROP_CNT_WIDTH-1:0] sat_inc(input logic [DROP_CNT_WIDTH-1:0] v);
        return (v == {DROP_CNT_WIDTH{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/axi_stream_extractor_fifo.sv
// Single-channel synchronous FIFO with a registered head word.
// The head register holds its last value once the FIFO runs empty.
module axi_stream_extractor_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             push_en, pop_en;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign head    = head_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (push_en) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // Head follows the next stored word; a push only reaches it when nothing older remains.
        if (pop_en) begin
            if (count_q > CW'(1)) begin
                head_d = mem_q[rd_ptr_d];
            end else if (push_en) begin
                head_d = din;
            end
        end else if (push_en && empty) begin
            head_d = din;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

endmodule

// File: rtl/axi_stream_multi_extractor.sv
// Copies beats from one shared stream to every enabled channel whose selector matches dest,
// rewriting dest per channel, with a per-channel FIFO and backpressure or counted drops.
module axi_stream_multi_extractor
    import axi_stream_extractor_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int DEST_WIDTH   = 8,
    parameter int USER_WIDTH   = 16,
    parameter int N_CHANNELS   = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int DROP_ON_FULL = MODE_BACKPRESSURE
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [N_CHANNELS*DEST_WIDTH-1:0]   selector,
    input  logic [N_CHANNELS*DEST_WIDTH-1:0]   out_dest,
    input  logic [N_CHANNELS-1:0]              enable,
    input  logic                               stream_in_valid,
    output logic                               stream_in_ready,
    input  logic [DATA_WIDTH-1:0]              stream_in_data,
    input  logic [USER_WIDTH-1:0]              stream_in_user,
    input  logic [DEST_WIDTH-1:0]              stream_in_dest,
    input  logic                               stream_in_tlast,
    output logic [N_CHANNELS-1:0]              stream_out_valid,
    input  logic [N_CHANNELS-1:0]              stream_out_ready,
    output logic [N_CHANNELS*DATA_WIDTH-1:0]   stream_out_data,
    output logic [N_CHANNELS*USER_WIDTH-1:0]   stream_out_user,
    output logic [N_CHANNELS*DEST_WIDTH-1:0]   stream_out_dest,
    output logic [N_CHANNELS-1:0]              stream_out_tlast,
    output logic [N_CHANNELS*DROP_CNT_WIDTH-1:0] drop_count
);
    localparam int PW = DATA_WIDTH + USER_WIDTH + DEST_WIDTH + 1;

    logic [N_CHANNELS-1:0]     match, full, empty, push, drop_inc;
    logic                      accept;
    logic [DROP_CNT_WIDTH-1:0] drop_q [N_CHANNELS];
    logic [DROP_CNT_WIDTH-1:0] drop_d [N_CHANNELS];

    always_comb begin
        match = '0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            match[i] = enable[i] && (stream_in_dest == selector[i*DEST_WIDTH +: DEST_WIDTH]);
        end
    end

    // Ready looks only at registered fullness, so a same-cycle pop never frees room for a push.
    always_comb begin
        if (DROP_ON_FULL == MODE_DROP) begin
            stream_in_ready = reset;
        end else begin
            stream_in_ready = reset && !(|(match & full));
        end
    end

    assign accept   = stream_in_valid && stream_in_ready;
    assign push     = {N_CHANNELS{accept}} & match & ~full;
    assign drop_inc = (DROP_ON_FULL == MODE_DROP) ? ({N_CHANNELS{accept}} & match & full) : '0;

    always_comb begin
        for (int i = 0; i < N_CHANNELS; i++) begin
            drop_d[i] = drop_inc[i] ? sat_inc(drop_q[i]) : drop_q[i];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_CHANNELS; i++) begin
                drop_q[i] <= '0;
            end
        end else begin
            drop_q <= drop_d;
        end
    end

    for (genvar g = 0; g < N_CHANNELS; g++) begin : g_chan
        logic [PW-1:0] din, head;

        assign din = {stream_in_data, stream_in_user,
                      out_dest[g*DEST_WIDTH +: DEST_WIDTH], stream_in_tlast};

        axi_stream_extractor_fifo #(
            .WIDTH (PW),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clock (clock),
            .reset (reset),
            .push  (push[g]),
            .pop   (stream_out_ready[g]),
            .din   (din),
            .full  (full[g]),
            .empty (empty[g]),
            .head  (head)
        );

        assign stream_out_valid[g] = !empty[g];
        assign {stream_out_data[g*DATA_WIDTH +: DATA_WIDTH],
                stream_out_user[g*USER_WIDTH +: USER_WIDTH],
                stream_out_dest[g*DEST_WIDTH +: DEST_WIDTH],
                stream_out_tlast[g]} = head;
        assign drop_count[g*DROP_CNT_WIDTH +: DROP_CNT_WIDTH] = drop_q[g];
    end

endmodule
